// File: rtl/ram_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port RAM between the CPU path and the program loader.
// Latency : write done 2 cycles after req is sampled in IDLE; read done 2+RD_LATENCY cycles after.
// Backpres: req/done handshake; a requester holds req until its done pulse, one access at a time.
//
// Ports:
//   i_clock, i_reset_n                          clock, async active-low reset
//   i_cpu_req/we/addr/wdata, o_cpu_gnt/done/rdata  CPU requester handshake and data
//   i_ldr_req/we/addr/wdata, o_ldr_gnt/done/rdata  loader requester handshake and data
//   o_ram_addr/we/wdata, i_ram_rdata              RAM macro interface
//   o_busy                                       high whenever an access is in progress
module ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_done,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  input  logic                  i_ldr_req,
  input  logic                  i_ldr_we,
  input  logic [ADDR_WIDTH-1:0] i_ldr_addr,
  input  logic [DATA_WIDTH-1:0] i_ldr_wdata,
  output logic                  o_ldr_gnt,
  output logic                  o_ldr_done,
  output logic [DATA_WIDTH-1:0] o_ldr_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_we,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic       OWN_CPU   = 1'b0;
  localparam logic       OWN_LDR   = 1'b1;
  // WAIT runs RD_LATENCY cycles: counter loads latency-1 and captures at zero.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;
  logic                  pick_cpu, pick_ldr;

  // On a tie the requester that did not win last time goes first.
  assign pick_cpu = i_cpu_req && (!i_ldr_req || (last_q == OWN_LDR));
  assign pick_ldr = i_ldr_req && !pick_cpu;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_LDR;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (pick_cpu || pick_ldr) begin
          owner_d = pick_ldr;
          last_d  = pick_ldr;
          we_d    = pick_ldr ? i_ldr_we    : i_cpu_we;
          addr_d  = pick_ldr ? i_ldr_addr  : i_cpu_addr;
          wdata_d = pick_ldr ? i_ldr_wdata : i_cpu_wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (owner_q == OWN_LDR) ldr_rdata_d = i_ram_rdata;
          else                    cpu_rdata_d = i_ram_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; grant spans ACCESS..DONE, i.e. every non-idle state.
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_cpu_gnt  = o_busy && (owner_q == OWN_CPU);
    o_ldr_gnt  = o_busy && (owner_q == OWN_LDR);
    o_cpu_done = (state_q == S_DONE) && (owner_q == OWN_CPU);
    o_ldr_done = (state_q == S_DONE) && (owner_q == OWN_LDR);
    o_ram_we   = (state_q == S_ACCESS) && we_q;
  end

  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (read latency 1 and 3), each with its own RAM model.
// Vector table, hand-written corner sequences and randomized traffic against a shadow memory.
// Requester index 0 is the CPU, 1 is the loader.
module tb_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          gnt   [2][2];
  logic          done  [2][2];
  logic [DW-1:0] rdata [2][2];
  logic [AW-1:0] ram_addr  [2];
  logic          ram_we    [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];
  logic          busy      [2];

  logic [DW-1:0] shadow [2][16];
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .i_clock    (clk),
      .i_reset_n  (rst_n),
      .i_cpu_req  (req[g][0]),
      .i_cpu_we   (we[g][0]),
      .i_cpu_addr (addr[g][0]),
      .i_cpu_wdata(wdata[g][0]),
      .o_cpu_gnt  (gnt[g][0]),
      .o_cpu_done (done[g][0]),
      .o_cpu_rdata(rdata[g][0]),
      .i_ldr_req  (req[g][1]),
      .i_ldr_we   (we[g][1]),
      .i_ldr_addr (addr[g][1]),
      .i_ldr_wdata(wdata[g][1]),
      .o_ldr_gnt  (gnt[g][1]),
      .o_ldr_done (done[g][1]),
      .o_ldr_rdata(rdata[g][1]),
      .o_ram_addr (ram_addr[g]),
      .o_ram_we   (ram_we[g]),
      .o_ram_wdata(ram_wdata[g]),
      .i_ram_rdata(ram_rdata[g]),
      .o_busy     (busy[g])
    );

    // RAM model: data is only valid once the address has been presented for
    // the configured number of busy cycles; before that it returns a marker.
    logic [DW-1:0] mem [16];
    int age;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mem[i] <= '0;
        age <= 0;
      end else begin
        if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
        if (!busy[g])      age <= 0;
        else if (age < 15) age <= age + 1;
      end
    end
    assign ram_rdata[g] = (age >= (g == 0 ? 1 : 3)) ? mem[ram_addr[g]] : 16'hDEAD;
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [57:0] outs(input int d);
    return {gnt[d][0], gnt[d][1], done[d][0], done[d][1], rdata[d][0], rdata[d][1],
            ram_addr[d], ram_we[d], ram_wdata[d], busy[d]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One isolated transaction; inputs are scrambled after latching to show they are ignored.
  task automatic run_txn(input int d, input int r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int exp_lat);
    int o = 1 - r;
    int lat = -1, gcnt = 0, wecnt = 0, bad = 0;
    logic [DW-1:0] own_before = rdata[d][r];
    logic [DW-1:0] oth_before = rdata[d][o];
    we[d][r] = w; addr[d][r] = a; wdata[d][r] = wd; req[d][r] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        we[d][r] = ~w; addr[d][r] = ~a; wdata[d][r] = ~wd;
      end
      if (gnt[d][r]) gcnt++;
      if (gnt[d][o] || done[d][o]) bad++;
      if (ram_we[d]) begin
        wecnt++;
        if (ram_addr[d] !== a || ram_wdata[d] !== wd) bad++;
      end
      if (done[d][r]) begin
        lat = k;
        break;
      end
    end
    req[d][r] = 1'b0;
    chk("txn_latency", 64'(lat), 64'(exp_lat));
    chk("txn_rdata", 64'(rdata[d][r]), 64'(w ? own_before : exp_rd));
    chk("txn_other_rdata", 64'(rdata[d][o]), 64'(oth_before));
    chk("txn_gnt_cycles", 64'(gcnt), 64'(exp_lat));
    chk("txn_we_cycles", 64'(wecnt), 64'(w));
    chk("txn_isolation", 64'(bad), 64'd0);
    @(negedge clk);
    chk("txn_idle_after", 64'({busy[d], gnt[d][0], gnt[d][1], done[d][0], done[d][1]}), 64'd0);
    if (w) shadow[d][a] = wd;
  endtask

  // Random traffic from one requester; grant-to-done latency and read data checked.
  task automatic rnd_txns(input int d, input int r, input int n);
    for (int i = 0; i < n; i++) begin
      logic w;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      int gs, lat;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w  = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 3));
      wd = 16'($urandom);
      we[d][r] = w; addr[d][r] = a; wdata[d][r] = wd; req[d][r] = 1'b1;
      gs = -1; lat = -1;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        if (gnt[d][r] && gs < 0) gs = k;
        if (done[d][r]) begin
          lat = k - gs;
          if (!w) chk("rnd_rdata", 64'(rdata[d][r]), 64'(shadow[d][a]));
          else    shadow[d][a] = wd;
          break;
        end
      end
      req[d][r] = 1'b0;
      chk("rnd_latency", 64'(lat), 64'(w ? 1 : 1 + lat_of(d)));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("mon_gnt_mutex", 64'(gnt[d][0] && gnt[d][1]), 64'd0);
        chk("mon_done_mutex", 64'(done[d][0] && done[d][1]), 64'd0);
        chk("mon_gnt_busy", 64'((gnt[d][0] || gnt[d][1] || ram_we[d]) && !busy[d]), 64'd0);
      end
    end
  end

  typedef struct {
    int            who;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    int            lat;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int   own_q [$];
    int   gap_q [$];
    int   quiet, both, idle_run, waitc;
    bit   seen_busy;
    logic pc, pl, pb;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) begin
        req[d][r] = 1'b0; we[d][r] = 1'b0; addr[d][r] = '0; wdata[d][r] = '0;
      end

    // Reset, then idle with no requests.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("reset_outs", 64'(outs(d)), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("idle_outs", 64'(outs(d)), 64'd0);
    end

    // Single-requester vectors on the latency-1 instance.
    tbl[0] = '{0, 1'b1, 4'h3, 16'h0A5C, 16'h0000, 2};
    tbl[1] = '{1, 1'b0, 4'h3, 16'h0000, 16'h0A5C, 3};
    tbl[2] = '{1, 1'b1, 4'h5, 16'h1234, 16'h0000, 2};
    tbl[3] = '{0, 1'b0, 4'h5, 16'h0000, 16'h1234, 3};
    tbl[4] = '{0, 1'b1, 4'hF, 16'hFFFF, 16'h0000, 2};
    tbl[5] = '{1, 1'b0, 4'hF, 16'h0000, 16'hFFFF, 3};
    tbl[6] = '{0, 1'b0, 4'h0, 16'h0000, 16'h0000, 3};
    tbl[7] = '{1, 1'b0, 4'h3, 16'h0000, 16'h0A5C, 3};
    for (int i = 0; i < 8; i++)
      run_txn(0, tbl[i].who, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].lat);

    // Latency-3 instance: done five cycles after the read request.
    run_txn(1, 1, 1'b1, 4'h7, 16'hBEEF, 16'h0000, 2);
    run_txn(1, 0, 1'b0, 4'h7, 16'h0000, 16'hBEEF, 5);
    run_txn(1, 1, 1'b0, 4'h7, 16'h0000, 16'hBEEF, 5);

    // Reset pulse during the ACCESS cycle of a CPU write.
    we[0][0] = 1'b1; addr[0][0] = 4'h3; wdata[0][0] = 16'h5555; req[0][0] = 1'b1;
    @(negedge clk);
    chk("abort_we_before", 64'(ram_we[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_outs", 64'(outs(0)), 64'd0);
    req[0][0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0][0] || done[0][1] || ram_we[0] || busy[0]) quiet++;
    end
    chk("abort_quiet", 64'(quiet), 64'd0);

    // Both requesting continuously: strict alternation starting with the CPU.
    we[0][0] = 1'b0; addr[0][0] = 4'h1;
    we[0][1] = 1'b1; addr[0][1] = 4'h2; wdata[0][1] = 16'h2222;
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    both = 0; idle_run = 0; seen_busy = 1'b0; pc = 1'b0; pl = 1'b0; pb = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt[0][0] && gnt[0][1]) both++;
      if (gnt[0][0] && !pc) own_q.push_back(0);
      if (gnt[0][1] && !pl) own_q.push_back(1);
      if (!busy[0]) idle_run++;
      else if (!pb) begin
        if (seen_busy) gap_q.push_back(idle_run);
        seen_busy = 1'b1;
        idle_run  = 0;
      end
      pc = gnt[0][0]; pl = gnt[0][1]; pb = busy[0];
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    waitc = 0;
    while (busy[0] && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("alt_drain", 64'(busy[0]), 64'd0);
    chk("alt_gnt_mutex", 64'(both), 64'd0);
    chk("alt_enough_grants", 64'(own_q.size() >= 4), 64'd1);
    chk("alt_enough_gaps", 64'(gap_q.size() >= 3), 64'd1);
    for (int i = 0; i < own_q.size(); i++) chk("alt_order", 64'(own_q[i]), 64'(i % 2));
    for (int i = 0; i < gap_q.size(); i++) chk("alt_idle_gap", 64'(gap_q[i]), 64'd1);

    // Known contents for the randomized phase.
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 4; a++)
        run_txn(d, a % 2, 1'b1, 4'(a), 16'($urandom), 16'h0000, 2);

    mon_en = 1'b1;
    fork
      rnd_txns(0, 0, 25);
      rnd_txns(0, 1, 25);
      rnd_txns(1, 0, 25);
      rnd_txns(1, 1, 25);
    join
    @(negedge clk);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
